// File: rtl/axi_to_mem_pkg.sv
// rtl/axi_to_mem_pkg.sv - shared encodings and FSM state type for the AXI-to-memory bridge
//
// Purpose: AXI burst and response encodings plus the bridge FSM state enum.
// Ports:   none (package).
package axi_to_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_SEND_B,
    ST_READ_ADDR,
    ST_READ_DATA
  } state_t;

endpackage

// File: rtl/axi_burst_next_addr.sv
// rtl/axi_burst_next_addr.sv - combinational AXI next-beat address generator
//
// Purpose: given the current beat address and the burst attributes, produce
//          the address of the following beat.
// Ports:
//   addr      in  ADDR_WIDTH  current beat byte address
//   len       in  8           AXI burst length (beats - 1)
//   size      in  3           log2 of bytes per beat
//   burst     in  2           FIXED / INCR / WRAP (reserved behaves as INCR)
//   next_addr out ADDR_WIDTH  address of the next beat
module axi_burst_next_addr
  import axi_to_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [7:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] wrap_mask;

  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    incr_addr = addr + step;
    // Window of (len+1) beats; bits inside the mask wrap, bits above it are kept.
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);

    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_to_mem_bridge.sv
// rtl/axi_to_mem_bridge.sv - AXI4 slave turning bursts into single-beat memory accesses
//
// Purpose: accepts one AXI read or write burst at a time and issues one memory
//          access per beat on a simple synchronous port with 1-cycle read latency.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   aw_* / aw_ready                 AXI write-address channel
//   ar_* / ar_ready                 AXI read-address channel
//   w_data/w_strb/w_last/w_valid    AXI write-data channel, w_ready out
//   b_id/b_resp/b_valid, b_ready    AXI write response
//   r_id/r_data/r_resp/r_last/r_valid, r_ready   AXI read data
//   req_o/we_o/addr_o/be_o/data_o   memory request port
//   data_i                          memory read data, valid the cycle after the address
module axi_to_mem_bridge
  import axi_to_mem_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [ID_WIDTH-1:0]     aw_id,
  input  logic [ADDR_WIDTH-1:0]   aw_addr,
  input  logic [7:0]              aw_len,
  input  logic [2:0]              aw_size,
  input  logic [1:0]              aw_burst,
  input  logic                    aw_valid,
  output logic                    aw_ready,

  input  logic [ID_WIDTH-1:0]     ar_id,
  input  logic [ADDR_WIDTH-1:0]   ar_addr,
  input  logic [7:0]              ar_len,
  input  logic [2:0]              ar_size,
  input  logic [1:0]              ar_burst,
  input  logic                    ar_valid,
  output logic                    ar_ready,

  input  logic [DATA_WIDTH-1:0]   w_data,
  input  logic [DATA_WIDTH/8-1:0] w_strb,
  input  logic                    w_last,
  input  logic                    w_valid,
  output logic                    w_ready,

  output logic [ID_WIDTH-1:0]     b_id,
  output logic [1:0]              b_resp,
  output logic                    b_valid,
  input  logic                    b_ready,

  output logic [ID_WIDTH-1:0]     r_id,
  output logic [DATA_WIDTH-1:0]   r_data,
  output logic [1:0]              r_resp,
  output logic                    r_last,
  output logic                    r_valid,
  input  logic                    r_ready,

  output logic                    req_o,
  output logic                    we_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH/8-1:0] be_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  input  logic [DATA_WIDTH-1:0]   data_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] last_addr_q;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic                  rd_first_q;
  logic                  last_beat;
  logic                  write_beat;

  // Termination is by beat count, so w_last carries no information here.
  logic unused_w_last;
  assign unused_w_last = w_last;

  assign last_beat  = (cnt_q == len_q);
  assign write_beat = w_ready && w_valid;

  axi_burst_next_addr #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_addr (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_valid)      state_d = ST_WRITE;
        else if (ar_valid) state_d = ST_READ_ADDR;
      end
      ST_WRITE:     if (w_valid && last_beat) state_d = ST_SEND_B;
      ST_SEND_B:    if (b_ready) state_d = ST_IDLE;
      ST_READ_ADDR: state_d = ST_READ_DATA;
      ST_READ_DATA: if (r_ready) state_d = last_beat ? ST_IDLE : ST_READ_ADDR;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs. Handshake/strobe outputs are forced low while rst_n is held low.
  always_comb begin
    aw_ready = 1'b0;
    ar_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    r_valid  = 1'b0;
    r_last   = 1'b0;
    req_o    = 1'b0;
    we_o     = 1'b0;
    if (rst_n) begin
      case (state_q)
        ST_IDLE: begin
          aw_ready = 1'b1;
          ar_ready = !aw_valid;
        end
        ST_WRITE: begin
          w_ready = 1'b1;
          req_o   = w_valid;
          we_o    = w_valid;
        end
        ST_SEND_B:    b_valid = 1'b1;
        ST_READ_ADDR: req_o   = 1'b1;
        ST_READ_DATA: begin
          r_valid = 1'b1;
          r_last  = last_beat;
        end
        default: ;
      endcase
    end
  end

  assign b_resp = RESP_OKAY;
  assign r_resp = RESP_OKAY;
  assign b_id   = rst_n ? id_q : '0;
  assign r_id   = rst_n ? id_q : '0;
  assign data_o = w_data;
  assign be_o   = write_beat ? w_strb : {STRB_WIDTH{1'b1}};
  // Between beats the port shows the address of the most recent access.
  assign addr_o = req_o ? addr_q : last_addr_q;
  // First READ_DATA cycle forwards the memory directly; afterwards the held copy.
  assign r_data = !rst_n ? '0 : (rd_first_q ? data_i : r_data_q);

  // Burst bookkeeping and read-data holding register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q        <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      r_data_q    <= '0;
      rd_first_q  <= 1'b0;
    end else begin
      rd_first_q <= (state_q == ST_READ_ADDR);
      if (rd_first_q) r_data_q <= data_i;
      if (req_o) last_addr_q <= addr_q;

      case (state_q)
        ST_IDLE: begin
          if (aw_valid) begin
            id_q    <= aw_id;
            addr_q  <= aw_addr;
            len_q   <= aw_len;
            size_q  <= aw_size;
            burst_q <= aw_burst;
            cnt_q   <= '0;
          end else if (ar_valid) begin
            id_q    <= ar_id;
            addr_q  <= ar_addr;
            len_q   <= ar_len;
            size_q  <= ar_size;
            burst_q <= ar_burst;
            cnt_q   <= '0;
          end
        end
        ST_WRITE: begin
          if (w_valid) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 8'd1;
          end
        end
        ST_READ_DATA: begin
          if (r_ready && !last_beat) begin
            addr_q <= next_addr;
            cnt_q  <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_to_mem_bridge.sv
// tb/tb_axi_to_mem_bridge.sv - directed self-checking bench for axi_to_mem_bridge
module tb_axi_to_mem_bridge;
  import axi_to_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:0]  aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr, addr_o;
  logic [7:0]  aw_len, ar_len, w_strb, be_o;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic        aw_valid, aw_ready, ar_valid, ar_ready;
  logic [63:0] w_data, r_data, data_o, data_i;
  logic        w_last, w_valid, w_ready;
  logic        b_valid, b_ready, r_last, r_valid, r_ready;
  logic        req_o, we_o;

  int errors = 0;
  int checks = 0;
  int rd_req_cnt = 0;

  always #5 clk = ~clk;

  axi_to_mem_bridge #(.ID_WIDTH(1), .ADDR_WIDTH(32), .DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size),
    .aw_burst(aw_burst), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size),
    .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .r_id(r_id), .r_data(r_data), .r_resp(r_resp), .r_last(r_last), .r_valid(r_valid),
    .r_ready(r_ready),
    .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .be_o(be_o), .data_o(data_o), .data_i(data_i)
  );

  // Memory model: 1-cycle read latency returning the address; garbage otherwise.
  always @(posedge clk) begin
    if (req_o && !we_o) begin
      data_i     <= {32'h0, addr_o};
      rd_req_cnt <= rd_req_cnt + 1;
    end else begin
      data_i <= 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic aw_send(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = 3'd3; aw_burst = burst; aw_valid = 1'b1;
    #1 check("aw_ready", 64'(aw_ready), 64'd1);
    @(negedge clk);
    aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3'd3; ar_burst = burst; ar_valid = 1'b1;
    #1 check("ar_ready", 64'(ar_ready), 64'd1);
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  task automatic w_beat(input string tag, input logic [63:0] data, input logic [7:0] strb,
                        input logic last, input logic [31:0] exp_addr);
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    #1;
    check({tag, ".req"},  64'(req_o),    64'd1);
    check({tag, ".we"},   64'(we_o),     64'd1);
    check({tag, ".addr"}, 64'(addr_o),   64'(exp_addr));
    check({tag, ".be"},   64'(be_o),     64'(strb));
    check({tag, ".data"}, data_o,        data);
    @(negedge clk);
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic b_wait(input string tag, input logic exp_id, input int hold);
    int n = 0;
    #1;
    while (!b_valid && n < 8) begin @(negedge clk); #1; n++; end
    check({tag, ".b_valid"}, 64'(b_valid), 64'd1);
    check({tag, ".b_resp"},  64'(b_resp),  64'(RESP_OKAY));
    check({tag, ".b_id"},    64'(b_id),    64'(exp_id));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); #1;
      check({tag, ".b_hold"}, 64'(b_valid), 64'd1);
    end
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    #1 check({tag, ".b_done"}, 64'(b_valid), 64'd0);
  endtask

  task automatic r_beat(input string tag, input logic [63:0] exp_data, input logic exp_last,
                        input logic exp_id, input int hold);
    int n = 0;
    int req0;
    #1;
    while (!r_valid && n < 8) begin @(negedge clk); #1; n++; end
    check({tag, ".r_valid"}, 64'(r_valid), 64'd1);
    check({tag, ".r_data"},  r_data,       exp_data);
    check({tag, ".r_last"},  64'(r_last),  64'(exp_last));
    check({tag, ".r_id"},    64'(r_id),    64'(exp_id));
    check({tag, ".r_resp"},  64'(r_resp),  64'(RESP_OKAY));
    if (hold > 0) begin
      req0 = rd_req_cnt;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk); #1;
        check({tag, ".hold_valid"}, 64'(r_valid), 64'd1);
        check({tag, ".hold_data"},  r_data,       exp_data);
      end
      check({tag, ".hold_no_req"}, 64'(rd_req_cnt - req0), 64'd0);
    end
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    #1 check({tag, ".r_done"}, 64'(r_valid), 64'd0);
  endtask

  initial begin
    int seen_b;
    rst_n = 1'b0;
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0;
    b_ready = 1'b0; r_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst.aw_ready", 64'(aw_ready), 64'd0);
    check("rst.ar_ready", 64'(ar_ready), 64'd0);
    check("rst.req",      64'(req_o),    64'd0);
    check("rst.b_valid",  64'(b_valid),  64'd0);
    check("rst.r_valid",  64'(r_valid),  64'd0);
    check("rst.r_data",   r_data,        64'd0);
    check("rst.b_id",     64'(b_id),     64'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("idle.aw_ready", 64'(aw_ready), 64'd1);
    check("idle.ar_ready", 64'(ar_ready), 64'd1);
    check("idle.be",       64'(be_o),     64'hFF);
    @(negedge clk);

    // 1. Single write
    aw_send(1'b1, 32'h10, 8'd0, BURST_INCR);
    w_beat("t1.w", 64'hA5, 8'h01, 1'b1, 32'h10);
    #1;
    check("t1.req_idle", 64'(req_o), 64'd0);
    check("t1.be_idle",  64'(be_o),  64'hFF);
    b_wait("t1", 1'b1, 0);
    @(negedge clk);

    // 2. INCR read
    ar_send(1'b0, 32'h20, 8'd3, BURST_INCR);
    r_beat("t2.b0", 64'h20, 1'b0, 1'b0, 0);
    r_beat("t2.b1", 64'h28, 1'b0, 1'b0, 0);
    r_beat("t2.b2", 64'h30, 1'b0, 1'b0, 0);
    r_beat("t2.b3", 64'h38, 1'b1, 1'b0, 0);
    @(negedge clk);

    // 3. WRAP read, FIXED write
    ar_send(1'b1, 32'h38, 8'd3, BURST_WRAP);
    r_beat("t3.b0", 64'h38, 1'b0, 1'b1, 0);
    r_beat("t3.b1", 64'h20, 1'b0, 1'b1, 0);
    r_beat("t3.b2", 64'h28, 1'b0, 1'b1, 0);
    r_beat("t3.b3", 64'h30, 1'b1, 1'b1, 0);
    @(negedge clk);
    aw_send(1'b0, 32'h40, 8'd2, BURST_FIXED);
    w_beat("t3.w0", 64'h1111, 8'h0F, 1'b0, 32'h40);
    w_beat("t3.w1", 64'h2222, 8'hF0, 1'b0, 32'h40);
    w_beat("t3.w2", 64'h3333, 8'hFF, 1'b1, 32'h40);
    b_wait("t3", 1'b0, 0);
    @(negedge clk);

    // INCR crossing the top of the address space
    ar_send(1'b0, 32'hFFFF_FFF8, 8'd1, BURST_INCR);
    r_beat("top.b0", 64'hFFFF_FFF8, 1'b0, 1'b0, 0);
    r_beat("top.b1", 64'h0,         1'b1, 1'b0, 0);
    @(negedge clk);

    // 4. Back-pressure on R and B
    ar_send(1'b0, 32'h100, 8'd3, BURST_INCR);
    r_beat("t4.b0", 64'h100, 1'b0, 1'b0, 0);
    r_beat("t4.b1", 64'h108, 1'b0, 1'b0, 5);
    r_beat("t4.b2", 64'h110, 1'b0, 1'b0, 0);
    r_beat("t4.b3", 64'h118, 1'b1, 1'b0, 0);
    @(negedge clk);
    aw_send(1'b1, 32'h180, 8'd0, BURST_INCR);
    w_beat("t4.w", 64'hCAFE, 8'hFF, 1'b1, 32'h180);
    b_wait("t4", 1'b1, 3);
    @(negedge clk);

    // 5. Simultaneous AW and AR
    aw_id = 1'b0; aw_addr = 32'h80; aw_len = 8'd0; aw_size = 3'd3; aw_burst = BURST_INCR;
    ar_id = 1'b1; ar_addr = 32'h90; ar_len = 8'd1; ar_size = 3'd3; ar_burst = BURST_INCR;
    aw_valid = 1'b1; ar_valid = 1'b1;
    #1;
    check("t5.aw_ready", 64'(aw_ready), 64'd1);
    check("t5.ar_ready", 64'(ar_ready), 64'd0);
    @(negedge clk);
    aw_valid = 1'b0;
    #1;
    check("t5.ar_ready_w", 64'(ar_ready), 64'd0);
    check("t5.w_ready",    64'(w_ready),  64'd1);
    w_beat("t5.w", 64'h55, 8'hFF, 1'b1, 32'h80);
    #1;
    check("t5.ar_ready_b", 64'(ar_ready), 64'd0);
    check("t5.b_valid",    64'(b_valid),  64'd1);
    b_ready = 1'b1;
    @(negedge clk);
    b_ready = 1'b0;
    #1;
    check("t5.ar_ready_idle", 64'(ar_ready), 64'd1);
    @(negedge clk);
    ar_valid = 1'b0;
    r_beat("t5.b0", 64'h90, 1'b0, 1'b1, 0);
    r_beat("t5.b1", 64'h98, 1'b1, 1'b1, 0);
    @(negedge clk);

    // 6. Reset in the middle of a len=7 write
    aw_send(1'b0, 32'h200, 8'd7, BURST_INCR);
    w_beat("t6.w0", 64'h0, 8'hFF, 1'b0, 32'h200);
    w_beat("t6.w1", 64'h1, 8'hFF, 1'b0, 32'h208);
    w_beat("t6.w2", 64'h2, 8'hFF, 1'b0, 32'h210);
    w_data = 64'h3; w_strb = 8'hFF; w_valid = 1'b1; rst_n = 1'b0;
    #1;
    check("t6.rst_req",     64'(req_o),   64'd0);
    check("t6.rst_w_ready", 64'(w_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; w_valid = 1'b0;
    #1;
    check("t6.idle_aw_ready", 64'(aw_ready), 64'd1);
    check("t6.idle_w_ready",  64'(w_ready),  64'd0);
    seen_b = 0;
    for (int i = 0; i < 4; i++) begin
      if (b_valid) seen_b++;
      @(negedge clk); #1;
    end
    check("t6.no_b", 64'(seen_b), 64'd0);
    @(negedge clk);
    ar_send(1'b1, 32'h300, 8'd1, BURST_INCR);
    r_beat("t6.b0", 64'h300, 1'b0, 1'b1, 0);
    r_beat("t6.b1", 64'h308, 1'b1, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
